clk_burst_ctrl: RTL and testbench



---
 rtl/clk_burst_ctrl.sv | 142 ++++++++++++++
 tb/tb_clk_burst_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/clk_burst_ctrl.sv
// clk_burst_ctrl
// Emits a counted burst of N square-wave periods on `out`. Each half-period
// lasts H clk cycles. When the burst ends, `out` returns to 0 and completion
// is reported. A running burst can be aborted.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : burst request, acted on only in IDLE
//   abort      : stop a running burst; also drops a coincident start in IDLE
//   div_half   : half-period H in clk cycles (0 treated as 1), latched at start
//   burst_len  : number of full periods N, latched at start
//   out        : gated divided clock (registered)
//   busy       : high while a burst runs
//   done       : one-cycle pulse on normal completion (or immediate, for N=0)
//   aborted    : one-cycle pulse when a running burst is aborted
//   period_cnt : completed periods of the current or last burst
module clk_burst_ctrl #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   div_half,
  input  logic [BURST_W-1:0] burst_len,
  output logic               out,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [BURST_W-1:0] period_cnt
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] pcnt_q, pcnt_d;
  logic               out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  logic [CNT_W-1:0]   half_eff;
  logic [BURST_W-1:0] pcnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      half_q    <= '0;
      hcnt_q    <= '0;
      len_q     <= '0;
      pcnt_q    <= '0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      hcnt_q    <= hcnt_d;
      len_q     <= len_d;
      pcnt_q    <= pcnt_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    hcnt_d    = hcnt_q;
    len_d     = len_q;
    pcnt_d    = pcnt_q;
    out_d     = out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    // A zero half-period would never toggle, so it behaves as one cycle.
    half_eff  = (div_half == '0) ? CNT_W'(1) : div_half;
    pcnt_inc  = pcnt_q + BURST_W'(1);

    unique case (state_q)
      IDLE: begin
        // Abort in IDLE suppresses a coincident start and produces no pulse.
        if (start && !abort) begin
          pcnt_d = '0;
          if (burst_len == '0) begin
            done_d = 1'b1;
          end else begin
            half_d  = half_eff;
            len_d   = burst_len;
            hcnt_d  = half_eff - CNT_W'(1);
            out_d   = 1'b1;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          // Abort outranks a completion on the same edge; period_cnt holds.
          out_d     = 1'b0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (hcnt_q != '0) begin
          hcnt_d = hcnt_q - CNT_W'(1);
        end else begin
          hcnt_d = half_q - CNT_W'(1);
          if (out_q) begin
            out_d = 1'b0;
          end else begin
            // Low-to-high transition closes a full period.
            pcnt_d = pcnt_inc;
            if (pcnt_inc == len_q) begin
              out_d   = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              out_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out        = out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign period_cnt = pcnt_q;

endmodule

// File: tb/tb_clk_burst_ctrl.sv
module tb_clk_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] div_half = '0;
  logic [7:0] burst_len = '0;
  logic       out, busy, done, aborted;
  logic [7:0] period_cnt;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic       o;
    logic       b;
    logic       d;
    logic       a;
    logic [7:0] p;
  } exp_t;

  exp_t q[$];

  clk_burst_ctrl #(.CNT_W(8), .BURST_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .div_half(div_half), .burst_len(burst_len),
    .out(out), .busy(busy), .done(done), .aborted(aborted),
    .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  // Expected per-edge outputs from the start edge onward, closed form.
  // ab >= 0 is the edge index (relative to start) at which abort is sampled.
  function automatic void push_burst(input int h, input int n, input int ab);
    int he;
    he = (h == 0) ? 1 : h;
    for (int i = 0; i < 2 * he * n; i++) begin
      if (i == ab) begin
        q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 8'((i - 1) / (2 * he))});
        q.push_back({4'b0000, 8'((i - 1) / (2 * he))});
        return;
      end
      q.push_back({((i / he) % 2) == 0, 1'b1, 1'b0, 1'b0, 8'(i / (2 * he))});
    end
    q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 8'(n)});
    q.push_back({4'b0000, 8'(n)});
  endfunction

  task automatic test_reset();
    exp_t got;
    #12;
    got = {out, busy, done, aborted, period_cnt};
    total++;
    if (got === 12'h000) passed++;
    else $display("FAIL reset got=%h exp=000", got);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // noise: re-assert start on edges 1..3 and change div_half/burst_len mid-burst
  task automatic test_burst(input int h, input int n, input int ab, input bit noise);
    exp_t e, got;
    q.delete();
    push_burst(h, n, ab);
    @(negedge clk);
    div_half  = 8'(h);
    burst_len = 8'(n);
    start     = 1'b1;
    abort     = 1'b0;
    @(posedge clk);
    #1;
    for (int idx = 0; q.size() > 0; idx++) begin
      e   = q.pop_front();
      got = {out, busy, done, aborted, period_cnt};
      total++;
      if (got === e) passed++;
      else $display("FAIL burst_h%0d_n%0d cyc%0d got=%h exp=%h", h, n, idx, got, e);
      start = noise && (idx < 3);
      abort = (idx + 1 == ab);
      if (noise && idx == 0) begin
        div_half  = 8'd9;
        burst_len = 8'd7;
      end
      if (q.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_idle_abort(input logic [7:0] pc);
    exp_t got;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    div_half  = 8'd2;
    burst_len = 8'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) start = 1'b0;
      got = {out, busy, done, aborted, period_cnt};
      total++;
      if (got === {4'b0000, pc}) passed++;
      else $display("FAIL idle_abort cyc%0d got=%h exp=%h", i, got, {4'b0000, pc});
    end
    abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e, got;
    q.delete();
    push_burst(1, 2, -1);
    void'(q.pop_back());
    push_burst(2, 1, -1);
    @(negedge clk);
    div_half  = 8'd1;
    burst_len = 8'd2;
    start     = 1'b1;
    @(posedge clk);
    #1;
    for (int idx = 0; q.size() > 0; idx++) begin
      e   = q.pop_front();
      got = {out, busy, done, aborted, period_cnt};
      total++;
      if (got === e) passed++;
      else $display("FAIL back_to_back cyc%0d got=%h exp=%h", idx, got, e);
      start = (idx == 4);
      if (idx == 4) begin
        div_half  = 8'd2;
        burst_len = 8'd1;
      end
      if (q.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t got;
    @(negedge clk);
    div_half  = 8'd4;
    burst_len = 8'd5;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    got = {out, busy, done, aborted, period_cnt};
    total++;
    if (got === 12'h400) passed++;
    else $display("FAIL pre_reset_running got=%h exp=400", got);
    #2;
    rst_n = 1'b0;
    #1;
    got = {out, busy, done, aborted, period_cnt};
    total++;
    if (got === 12'h000) passed++;
    else $display("FAIL async_reset got=%h exp=000", got);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {out, busy, done, aborted, period_cnt};
    total++;
    if (got === 12'h000) passed++;
    else $display("FAIL after_reset_idle got=%h exp=000", got);
  endtask

  initial begin
    test_reset();
    test_burst(2, 3, -1, 1'b0);
    test_burst(0, 2, -1, 1'b0);
    test_burst(5, 0, -1, 1'b0);
    test_burst(3, 4, 8, 1'b0);
    test_idle_abort(8'd1);
    test_burst(1, 2, -1, 1'b1);
    test_back_to_back();
    test_burst(255, 2, -1, 1'b0);
    test_burst(1, 255, -1, 1'b0);
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
